// File: rtl/pipe_hazard_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : pipe_hazard_ctrl
// Purpose  : D-stage stall, forwarding selects and mult/div busy timer for a
//            5-stage MIPS pipeline, tracked with private E/M/W shadow records.
// Revision : 1.0  initial release
// ============================================================================
module pipe_hazard_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10,
  parameter int CNT_W       = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] ir_d,
  output logic        stall,
  output logic [1:0]  fwd_rs_d,
  output logic [1:0]  fwd_rt_d,
  output logic [1:0]  fwd_rs_e,
  output logic [1:0]  fwd_rt_e,
  output logic        fwd_rt_m,
  output logic        md_start,
  output logic        md_busy
);

  localparam logic [5:0] c_OP_RTYPE = 6'h00;
  localparam logic [5:0] c_OP_J     = 6'h02;
  localparam logic [5:0] c_OP_JAL   = 6'h03;
  localparam logic [5:0] c_OP_BEQ   = 6'h04;
  localparam logic [5:0] c_OP_ORI   = 6'h0D;
  localparam logic [5:0] c_OP_LUI   = 6'h0F;
  localparam logic [5:0] c_OP_LW    = 6'h23;
  localparam logic [5:0] c_OP_SW    = 6'h2B;

  localparam logic [5:0] c_FN_JR    = 6'h08;
  localparam logic [5:0] c_FN_MFHI  = 6'h10;
  localparam logic [5:0] c_FN_MTHI  = 6'h11;
  localparam logic [5:0] c_FN_MFLO  = 6'h12;
  localparam logic [5:0] c_FN_MTLO  = 6'h13;
  localparam logic [5:0] c_FN_MULT  = 6'h18;
  localparam logic [5:0] c_FN_MULTU = 6'h19;
  localparam logic [5:0] c_FN_DIV   = 6'h1A;
  localparam logic [5:0] c_FN_DIVU  = 6'h1B;

  // Instruction fields
  logic [5:0] op;
  logic [5:0] funct;
  logic [4:0] rs_a;
  logic [4:0] rt_a;
  logic [4:0] rd_a;
  logic       unused_shamt;

  assign op           = ir_d[31:26];
  assign rs_a         = ir_d[25:21];
  assign rt_a         = ir_d[20:16];
  assign rd_a         = ir_d[15:11];
  assign funct        = ir_d[5:0];
  assign unused_shamt = ^ir_d[10:6];

  // Decoded D-stage attributes
  logic       rd_rs;
  logic       rd_rt;
  logic [1:0] tuse_rs;
  logic [1:0] tuse_rt;
  logic [4:0] dst_dec;
  logic [1:0] tnew_dec;
  logic       md_cls;
  logic       md_op;
  logic       md_div;

  // Shadow pipeline records
  logic [4:0] e_rs_q,   e_rs_d;
  logic [4:0] e_rt_q,   e_rt_d;
  logic [4:0] e_dst_q,  e_dst_d;
  logic [1:0] e_tnew_q, e_tnew_d;
  logic       e_md_q,   e_md_d;
  logic       e_div_q,  e_div_d;
  logic [4:0] m_rt_q,   m_rt_d;
  logic [4:0] m_dst_q,  m_dst_d;
  logic [1:0] m_tnew_q, m_tnew_d;
  logic [4:0] w_dst_q,  w_dst_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    rd_rs    = 1'b0;
    rd_rt    = 1'b0;
    tuse_rs  = 2'd0;
    tuse_rt  = 2'd0;
    dst_dec  = 5'd0;
    tnew_dec = 2'd0;
    md_cls   = 1'b0;
    md_op    = 1'b0;
    md_div   = 1'b0;
    case (op)
      c_OP_RTYPE: begin
        case (funct)
          c_FN_JR: begin
            rd_rs = 1'b1;
          end
          c_FN_MULT, c_FN_MULTU, c_FN_DIV, c_FN_DIVU: begin
            rd_rs   = 1'b1;
            rd_rt   = 1'b1;
            tuse_rs = 2'd1;
            tuse_rt = 2'd1;
            md_cls  = 1'b1;
            md_op   = 1'b1;
            md_div  = (funct == c_FN_DIV) || (funct == c_FN_DIVU);
          end
          c_FN_MTHI, c_FN_MTLO: begin
            rd_rs   = 1'b1;
            tuse_rs = 2'd1;
            md_cls  = 1'b1;
          end
          c_FN_MFHI, c_FN_MFLO: begin
            dst_dec  = rd_a;
            tnew_dec = 2'd1;
            md_cls   = 1'b1;
          end
          default: begin
            rd_rs    = 1'b1;
            rd_rt    = 1'b1;
            tuse_rs  = 2'd1;
            tuse_rt  = 2'd1;
            dst_dec  = rd_a;
            tnew_dec = 2'd1;
          end
        endcase
      end
      c_OP_ORI, c_OP_LUI: begin
        rd_rs    = 1'b1;
        tuse_rs  = 2'd1;
        dst_dec  = rt_a;
        tnew_dec = 2'd1;
      end
      c_OP_LW: begin
        rd_rs    = 1'b1;
        tuse_rs  = 2'd1;
        dst_dec  = rt_a;
        tnew_dec = 2'd2;
      end
      c_OP_SW: begin
        rd_rs   = 1'b1;
        rd_rt   = 1'b1;
        tuse_rs = 2'd1;
        tuse_rt = 2'd2;
      end
      c_OP_BEQ: begin
        rd_rs = 1'b1;
        rd_rt = 1'b1;
      end
      c_OP_JAL: begin
        dst_dec  = 5'd31;
        tnew_dec = 2'd0;
      end
      c_OP_J: begin
      end
      default: begin
      end
    endcase
  end

  assign md_start = e_md_q;
  assign md_busy  = (cnt_q != '0);

  // A producer still too far from its result for this operand's use point.
  always_comb begin
    stall = 1'b0;
    if (rd_rs && (rs_a != 5'd0)) begin
      if ((e_dst_q == rs_a) && (e_tnew_q > tuse_rs)) stall = 1'b1;
      if ((m_dst_q == rs_a) && (m_tnew_q > tuse_rs)) stall = 1'b1;
    end
    if (rd_rt && (rt_a != 5'd0)) begin
      if ((e_dst_q == rt_a) && (e_tnew_q > tuse_rt)) stall = 1'b1;
      if ((m_dst_q == rt_a) && (m_tnew_q > tuse_rt)) stall = 1'b1;
    end
    if (md_cls && (md_start || md_busy)) stall = 1'b1;
  end

  function automatic logic [1:0] src_sel(
    input logic       use_e,
    input logic [4:0] addr,
    input logic [4:0] ed,
    input logic [1:0] et,
    input logic [4:0] md,
    input logic [1:0] mt,
    input logic [4:0] wd
  );
    logic [1:0] sel;
    sel = 2'd0;
    if (addr != 5'd0) begin
      if (use_e && (ed == addr) && (et == 2'd0)) sel = 2'd1;
      else if ((md == addr) && (mt == 2'd0))    sel = 2'd2;
      else if (wd == addr)                       sel = 2'd3;
    end
    return sel;
  endfunction

  always_comb begin
    fwd_rs_d = src_sel(1'b1, rd_rs ? rs_a : 5'd0, e_dst_q, e_tnew_q, m_dst_q, m_tnew_q, w_dst_q);
    fwd_rt_d = src_sel(1'b1, rd_rt ? rt_a : 5'd0, e_dst_q, e_tnew_q, m_dst_q, m_tnew_q, w_dst_q);
    fwd_rs_e = src_sel(1'b0, e_rs_q, e_dst_q, e_tnew_q, m_dst_q, m_tnew_q, w_dst_q);
    fwd_rt_e = src_sel(1'b0, e_rt_q, e_dst_q, e_tnew_q, m_dst_q, m_tnew_q, w_dst_q);
    fwd_rt_m = (m_rt_q != 5'd0) && (w_dst_q == m_rt_q);
  end

  always_comb begin
    e_rs_d   = 5'd0;
    e_rt_d   = 5'd0;
    e_dst_d  = 5'd0;
    e_tnew_d = 2'd0;
    e_md_d   = 1'b0;
    e_div_d  = 1'b0;
    if (!stall) begin
      e_rs_d   = rd_rs ? rs_a : 5'd0;
      e_rt_d   = rd_rt ? rt_a : 5'd0;
      e_dst_d  = dst_dec;
      e_tnew_d = tnew_dec;
      e_md_d   = md_op;
      e_div_d  = md_div;
    end
    m_rt_d   = e_rt_q;
    m_dst_d  = e_dst_q;
    m_tnew_d = (e_tnew_q == 2'd0) ? 2'd0 : (e_tnew_q - 2'd1);
    w_dst_d  = m_dst_q;
  end

  always_comb begin
    cnt_d = cnt_q;
    if (md_start)          cnt_d = e_div_q ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
    else if (cnt_q != '0)  cnt_d = cnt_q - CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      e_rs_q   <= 5'd0;
      e_rt_q   <= 5'd0;
      e_dst_q  <= 5'd0;
      e_tnew_q <= 2'd0;
      e_md_q   <= 1'b0;
      e_div_q  <= 1'b0;
      m_rt_q   <= 5'd0;
      m_dst_q  <= 5'd0;
      m_tnew_q <= 2'd0;
      w_dst_q  <= 5'd0;
      cnt_q    <= '0;
    end else begin
      e_rs_q   <= e_rs_d;
      e_rt_q   <= e_rt_d;
      e_dst_q  <= e_dst_d;
      e_tnew_q <= e_tnew_d;
      e_md_q   <= e_md_d;
      e_div_q  <= e_div_d;
      m_rt_q   <= m_rt_d;
      m_dst_q  <= m_dst_d;
      m_tnew_q <= m_tnew_d;
      w_dst_q  <= w_dst_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_pipe_hazard_ctrl
// Purpose  : directed and random instruction streams against a record-list model
// Revision : 1.0  initial release
// ============================================================================
module tb_pipe_hazard_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] ir_d;
  logic        stall;
  logic [1:0]  fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e;
  logic        fwd_rt_m, md_start, md_busy;

  int checks = 0;
  int errors = 0;
  int last_rs_d, last_rt_d;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10), .CNT_W(4)) dut (
    .clk(clk), .reset(reset), .ir_d(ir_d), .stall(stall),
    .fwd_rs_d(fwd_rs_d), .fwd_rt_d(fwd_rt_d), .fwd_rs_e(fwd_rs_e), .fwd_rt_e(fwd_rt_e),
    .fwd_rt_m(fwd_rt_m), .md_start(md_start), .md_busy(md_busy)
  );

  typedef struct { int rs; int rt; int dst; int tnew; bit md; bit dv; } rec_t;
  typedef struct { int tuse_rs; int tuse_rt; int dst; int tnew; bit mdcls; bit md; bit dv; } dec_t;

  rec_t stg [3];   // 0 = E, 1 = M, 2 = W
  int   busy_left;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got=%0d expected=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] r_ins(input logic [5:0] fn, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [4:0] rd);
    return {6'd0, rs, rt, rd, 5'd0, fn};
  endfunction

  function automatic logic [31:0] i_ins(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  // tuse of -1 marks an operand that is not read
  function automatic dec_t decode(input logic [31:0] ir);
    dec_t d;
    d = '{-1, -1, 0, 0, 1'b0, 1'b0, 1'b0};
    case (ir[31:26])
      6'h00: case (ir[5:0])
        6'h08:             d.tuse_rs = 0;
        6'h18, 6'h19:      begin d.tuse_rs = 1; d.tuse_rt = 1; d.mdcls = 1; d.md = 1; end
        6'h1A, 6'h1B:      begin d.tuse_rs = 1; d.tuse_rt = 1; d.mdcls = 1; d.md = 1; d.dv = 1; end
        6'h11, 6'h13:      begin d.tuse_rs = 1; d.mdcls = 1; end
        6'h10, 6'h12:      begin d.dst = int'(ir[15:11]); d.tnew = 1; d.mdcls = 1; end
        default:           begin d.tuse_rs = 1; d.tuse_rt = 1; d.dst = int'(ir[15:11]); d.tnew = 1; end
      endcase
      6'h0D, 6'h0F: begin d.tuse_rs = 1; d.dst = int'(ir[20:16]); d.tnew = 1; end
      6'h23:        begin d.tuse_rs = 1; d.dst = int'(ir[20:16]); d.tnew = 2; end
      6'h2B:        begin d.tuse_rs = 1; d.tuse_rt = 2; end
      6'h04:        begin d.tuse_rs = 0; d.tuse_rt = 0; end
      6'h03:        begin d.dst = 31; d.tnew = 0; end
      default:      ;
    endcase
    return d;
  endfunction

  // nearest ready producer, scanning from 'first' stage outward
  function automatic int src_of(input int addr, input int first);
    if (addr == 0) return 0;
    for (int s = first; s < 3; s++)
      if (stg[s].dst == addr && stg[s].tnew == 0) return s + 1;
    return 0;
  endfunction

  function automatic bit late(input int addr, input int tuse);
    if (addr == 0 || tuse < 0) return 1'b0;
    for (int s = 0; s < 2; s++)
      if (stg[s].dst == addr && stg[s].tnew > tuse) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_clear();
    for (int s = 0; s < 3; s++) stg[s] = '{0, 0, 0, 0, 1'b0, 1'b0};
    busy_left = 0;
  endtask

  // Present one instruction for one cycle, check outputs, advance model on the edge.
  task automatic step(input logic [31:0] ir, output bit st);
    dec_t d;
    int   a_rs, a_rt;
    ir_d = ir;
    #1;
    d    = decode(ir);
    a_rs = (d.tuse_rs >= 0) ? int'(ir[25:21]) : 0;
    a_rt = (d.tuse_rt >= 0) ? int'(ir[20:16]) : 0;
    st   = late(a_rs, d.tuse_rs) || late(a_rt, d.tuse_rt) ||
           (d.mdcls && (stg[0].md || busy_left > 0));
    chk("stall", int'(stall), int'(st));
    chk("md_start", int'(md_start), int'(stg[0].md));
    chk("md_busy", int'(md_busy), int'(busy_left > 0));
    last_rs_d = int'(fwd_rs_d);
    last_rt_d = int'(fwd_rt_d);
    if (!st) begin
      chk("fwd_rs_d", int'(fwd_rs_d), src_of(a_rs, 0));
      chk("fwd_rt_d", int'(fwd_rt_d), src_of(a_rt, 0));
      chk("fwd_rs_e", int'(fwd_rs_e), src_of(stg[0].rs, 1));
      chk("fwd_rt_e", int'(fwd_rt_e), src_of(stg[0].rt, 1));
      chk("fwd_rt_m", int'(fwd_rt_m), int'(stg[1].rt != 0 && stg[2].dst == stg[1].rt));
    end
    @(posedge clk);
    if (reset) begin
      model_clear();
    end else begin
      if (stg[0].md)          busy_left = stg[0].dv ? 10 : 5;
      else if (busy_left > 0) busy_left--;
      stg[2] = stg[1];
      stg[2].tnew = 0;
      stg[1] = stg[0];
      if (stg[1].tnew > 0) stg[1].tnew--;
      if (st) stg[0] = '{0, 0, 0, 0, 1'b0, 1'b0};
      else    stg[0] = '{a_rs, a_rt, d.dst, d.tnew, d.md, d.dv};
    end
    #1;
  endtask

  // Hold an instruction in D until it is accepted; returns the stall cycles seen.
  task automatic issue(input logic [31:0] ir, output int nst);
    bit st;
    nst = 0;
    do begin
      step(ir, st);
      if (st) nst++;
      if (nst > 20) begin
        chk("stall_bound", nst, 20);
        st = 1'b0;
      end
    end while (st);
  endtask

  function automatic logic [4:0] rnd_reg();
    int r;
    r = int'($urandom_range(0, 4));
    return (r == 4) ? 5'd31 : 5'(r);
  endfunction

  function automatic logic [31:0] rnd_ins();
    logic [4:0] a, b, c;
    a = rnd_reg(); b = rnd_reg(); c = rnd_reg();
    case ($urandom_range(0, 18))
      0:  return r_ins(6'h21, a, b, c);
      1:  return r_ins(6'h23, a, b, c);
      2:  return i_ins(6'h0D, a, b, 16'h0001);
      3:  return i_ins(6'h0F, 5'd0, b, 16'h1234);
      4:  return i_ins(6'h23, a, b, 16'h0004);
      5:  return i_ins(6'h2B, a, b, 16'h0008);
      6:  return i_ins(6'h04, a, b, 16'h0002);
      7:  return {6'h02, 26'h10};
      8:  return {6'h03, 26'h20};
      9:  return r_ins(6'h08, a, 5'd0, 5'd0);
      10: return r_ins(6'h18, a, b, 5'd0);
      11: return r_ins(6'h19, a, b, 5'd0);
      12: return r_ins(6'h1A, a, b, 5'd0);
      13: return r_ins(6'h1B, a, b, 5'd0);
      14: return r_ins(6'h10, 5'd0, 5'd0, c);
      15: return r_ins(6'h12, 5'd0, 5'd0, c);
      16: return r_ins(6'h11, a, 5'd0, 5'd0);
      17: return r_ins(6'h13, a, 5'd0, 5'd0);
      default: return {6'h3F, a, b, c, 11'd0};
    endcase
  endfunction

  localparam logic [31:0] c_NOP = 32'h0;

  initial begin
    int n;
    bit st;
    reset = 1'b1;
    ir_d  = c_NOP;
    model_clear();
    @(posedge clk);
    @(posedge clk);
    #1;
    step(r_ins(6'h21, 5'd1, 5'd2, 5'd3), st);
    reset = 1'b0;

    // load-use: one bubble, then W forwarding into E
    issue(i_ins(6'h23, 5'd0, 5'd1, 16'h0), n);
    issue(r_ins(6'h21, 5'd1, 5'd1, 5'd2), n);
    chk("lw_use_stalls", n, 1);
    ir_d = c_NOP;
    #1;
    chk("lw_fwd_rs_e", int'(fwd_rs_e), 3);
    chk("lw_fwd_rt_e", int'(fwd_rt_e), 3);
    issue(c_NOP, n);

    // ALU result feeding a branch
    issue(r_ins(6'h21, 5'd1, 5'd1, 5'd3), n);
    issue(i_ins(6'h04, 5'd3, 5'd3, 16'h0), n);
    chk("beq_stalls", n, 1);
    chk("beq_fwd_rs_d", last_rs_d, 2);
    chk("beq_fwd_rt_d", last_rt_d, 2);

    // jal link value straight from E
    issue({6'h03, 26'h40}, n);
    issue(r_ins(6'h08, 5'd31, 5'd0, 5'd0), n);
    chk("jr_stalls", n, 0);
    chk("jr_fwd_rs_d", last_rs_d, 1);

    // mult then mflo
    issue(r_ins(6'h18, 5'd1, 5'd2, 5'd0), n);
    issue(r_ins(6'h12, 5'd0, 5'd0, 5'd5), n);
    chk("mflo_stalls", n, 6);

    // writes to $0 are invisible
    issue(i_ins(6'h0D, 5'd0, 5'd0, 16'h1), n);
    issue(r_ins(6'h21, 5'd0, 5'd0, 5'd4), n);
    chk("zero_stalls", n, 0);
    chk("zero_fwd_rs_d", last_rs_d, 0);

    // reset while a div sits in E
    issue(r_ins(6'h1A, 5'd1, 5'd2, 5'd0), n);
    reset = 1'b1;
    step(c_NOP, st);
    reset = 1'b0;
    ir_d = r_ins(6'h12, 5'd0, 5'd0, 5'd6);
    #1;
    chk("rst_md_busy", int'(md_busy), 0);
    chk("rst_stall", int'(stall), 0);
    issue(r_ins(6'h12, 5'd0, 5'd0, 5'd6), n);

    for (int i = 0; i < 400; i++) issue(rnd_ins(), n);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=0 expected=1");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
